// File: rtl/xs3_to_bcd_deser_if.sv
// rtl/xs3_to_bcd_deser_if.sv - digit input and frame result handshake bundle for xs3_to_bcd_deser
interface xs3_to_bcd_deser_if #(
  parameter int DIGITS = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [3:0]            in_xs3;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   out_bcd;
  logic [3:0]            out_ndigits;
  logic                  out_err;

  // digit source and result consumer side
  modport master (
    output in_valid, in_xs3, in_last, out_ready,
    input  in_ready, out_valid, out_bcd, out_ndigits, out_err
  );

  // decoder side
  modport slave (
    input  in_valid, in_xs3, in_last, out_ready,
    output in_ready, out_valid, out_bcd, out_ndigits, out_err
  );
endinterface

// File: rtl/xs3_to_bcd_deser.sv
// rtl/xs3_to_bcd_deser.sv - serial excess-3 digits to packed BCD frame decoder
module xs3_to_bcd_deser #(
  parameter int DIGITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  xs3_to_bcd_deser_if.slave    bus
);
  localparam int W = 4 * DIGITS;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           err_q, err_d;
  logic           in_ready_q, in_ready_d;
  logic           out_valid_q, out_valid_d;
  logic [W-1:0]   out_bcd_q, out_bcd_d;
  logic [3:0]     out_ndigits_q, out_ndigits_d;
  logic           out_err_q, out_err_d;

  logic           code_bad;
  logic [3:0]     digit;
  logic [3:0]     cnt_inc;
  logic [W-1:0]   acc_shift;

  // Codes outside 3..C are flagged and decode to zero so the word stays valid BCD
  assign code_bad = (bus.in_xs3 < 4'h3) || (bus.in_xs3 > 4'hC);
  assign digit    = code_bad ? 4'h0 : (bus.in_xs3 - 4'd3);
  assign cnt_inc  = cnt_q + 4'd1;

  // A one-digit accumulator has no upper bits to keep, so the shift degenerates to a load
  if (DIGITS == 1) begin : g_one
    assign acc_shift = digit;
  end else begin : g_many
    assign acc_shift = {acc_q[W-5:0], digit};
  end

  // State and output registers; reset discards any partial or held frame
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= COLLECT;
      acc_q         <= '0;
      cnt_q         <= 4'd0;
      err_q         <= 1'b0;
      in_ready_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_bcd_q     <= '0;
      out_ndigits_q <= 4'd0;
      out_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      err_q         <= err_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      out_bcd_q     <= out_bcd_d;
      out_ndigits_q <= out_ndigits_d;
      out_err_q     <= out_err_d;
    end
  end

  // Next state: shift digits in while collecting, publish the frame on entry to HOLD
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    in_ready_d    = in_ready_q;
    out_valid_d   = out_valid_q;
    out_bcd_d     = out_bcd_q;
    out_ndigits_d = out_ndigits_q;
    out_err_d     = out_err_q;
    case (state_q)
      COLLECT: begin
        // in_ready is low for one cycle after reset, then stays high while collecting
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        if (bus.in_valid && in_ready_q) begin
          acc_d = acc_shift;
          cnt_d = cnt_inc;
          err_d = err_q | code_bad;
          if (bus.in_last || (cnt_inc == 4'(DIGITS))) begin
            state_d       = HOLD;
            in_ready_d    = 1'b0;
            out_valid_d   = 1'b1;
            out_bcd_d     = acc_shift;
            out_ndigits_d = cnt_inc;
            out_err_d     = err_q | code_bad;
          end
        end
      end
      HOLD: begin
        if (bus.out_ready && out_valid_q) begin
          state_d     = COLLECT;
          acc_d       = '0;
          cnt_d       = 4'd0;
          err_d       = 1'b0;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_bcd     = out_bcd_q;
  assign bus.out_ndigits = out_ndigits_q;
  assign bus.out_err     = out_err_q;
endmodule

// File: tb/tb_xs3_to_bcd_deser.sv
// tb/tb_xs3_to_bcd_deser.sv - directed frame vectors and handshake corner cases for xs3_to_bcd_deser
module tb_xs3_to_bcd_deser;
  logic clk = 1'b0;
  logic rst_n;
  int   n_vec  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  xs3_to_bcd_deser_if #(.DIGITS(4)) bus ();

  xs3_to_bcd_deser #(.DIGITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    int          n;
    logic [15:0] digs;
    logic        last;
    logic [15:0] exp_bcd;
    logic [3:0]  exp_nd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one digit and hold it until accepted; inputs change #1 after the edge
  task automatic send_digit(input logic [3:0] code, input logic last);
    int t;
    bus.in_valid = 1'b1;
    bus.in_xs3   = code;
    bus.in_last  = last;
    t = 0;
    while (!bus.in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("in_ready_wait", 16'(bus.in_ready), 16'd1);
    @(posedge clk); #1;
  endtask

  task automatic run_frame(input vec_t v, input bit release_check);
    for (int i = 0; i < v.n; i++) begin
      send_digit(v.digs[15-4*i -: 4], v.last && (i == v.n - 1));
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check("out_valid", 16'(bus.out_valid), 16'd1);
    check("in_ready_hold", 16'(bus.in_ready), 16'd0);
    check("out_bcd", bus.out_bcd, v.exp_bcd);
    check("out_ndigits", 16'(bus.out_ndigits), 16'(v.exp_nd));
    check("out_err", 16'(bus.out_err), 16'(v.exp_err));
    if (release_check) begin
      @(posedge clk); #1;
      check("out_valid_drop", 16'(bus.out_valid), 16'd0);
      check("in_ready_back", 16'(bus.in_ready), 16'd1);
    end
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{4, 16'h485C, 1'b0, 16'h1529, 4'd4, 1'b0};
    vecs[1] = '{2, 16'h6A00, 1'b1, 16'h0037, 4'd2, 1'b0};
    vecs[2] = '{4, 16'h3F73, 1'b0, 16'h0040, 4'd4, 1'b1};
    vecs[3] = '{1, 16'hC000, 1'b1, 16'h0009, 4'd1, 1'b0};
    vecs[4] = '{3, 16'h34C0, 1'b1, 16'h0019, 4'd3, 1'b0};
    vecs[5] = '{4, 16'hCCCC, 1'b1, 16'h9999, 4'd4, 1'b0};
    vecs[6] = '{2, 16'hD000, 1'b1, 16'h0000, 4'd2, 1'b1};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_xs3    = 4'h0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 16'(bus.in_ready), 16'd0);
    check("rst_out_valid", 16'(bus.out_valid), 16'd0);
    check("rst_out_bcd", bus.out_bcd, 16'h0000);
    check("rst_out_nd", 16'(bus.out_ndigits), 16'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_rst", 16'(bus.in_ready), 16'd1);

    for (int k = 0; k < 7; k++) begin
      run_frame(vecs[k], 1'b1);
    end

    // Backpressure: result held while the source keeps offering changing digits
    bus.out_ready = 1'b0;
    v = '{4, 16'h5678, 1'b0, 16'h2345, 4'd4, 1'b0};
    run_frame(v, 1'b0);
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = 1'b1;
      bus.in_xs3   = 4'(4 + c);
      bus.in_last  = 1'b1;
      @(posedge clk); #1;
      check("bp_out_valid", 16'(bus.out_valid), 16'd1);
      check("bp_in_ready", 16'(bus.in_ready), 16'd0);
      check("bp_out_bcd", bus.out_bcd, 16'h2345);
      check("bp_out_nd", 16'(bus.out_ndigits), 16'd4);
    end
    bus.in_xs3    = 4'h9;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 16'(bus.out_valid), 16'd0);
    check("bp_release_ready", 16'(bus.in_ready), 16'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check("bp_next_valid", 16'(bus.out_valid), 16'd1);
    check("bp_next_bcd", bus.out_bcd, 16'h0006);
    check("bp_next_nd", 16'(bus.out_ndigits), 16'd1);
    @(posedge clk); #1;

    // Reset mid-frame discards the partial accumulator
    send_digit(4'h4, 1'b0);
    send_digit(4'h5, 1'b0);
    bus.in_valid = 1'b0;
    rst_n        = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_in_ready", 16'(bus.in_ready), 16'd0);
    check("mid_rst_out_valid", 16'(bus.out_valid), 16'd0);
    check("mid_rst_out_bcd", bus.out_bcd, 16'h0000);
    check("mid_rst_out_nd", 16'(bus.out_ndigits), 16'd0);
    check("mid_rst_out_err", 16'(bus.out_err), 16'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_ready_back", 16'(bus.in_ready), 16'd1);
    v = '{1, 16'h9000, 1'b1, 16'h0006, 4'd1, 1'b0};
    run_frame(v, 1'b1);

    // Reset during HOLD drops the pending result
    bus.out_ready = 1'b0;
    v = '{2, 16'hCC00, 1'b1, 16'h0099, 4'd2, 1'b0};
    run_frame(v, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("hold_rst_valid", 16'(bus.out_valid), 16'd0);
    check("hold_rst_bcd", bus.out_bcd, 16'h0000);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("hold_rst_no_result", 16'(bus.out_valid), 16'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
